// File: rtl/font_writer_pkg.sv
// Shared constants, FSM encoding and helper functions for the font writer.
// The FW_BG_CLEAR_EN macro (see font_writer.sv) selects opaque-background drawing.
package font_writer_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int TEXT_COLS  = 40;
  localparam int TEXT_ROWS  = 30;
  localparam int GLYPH_SIZE = 8;
  localparam int FB_ADDR_W  = $clog2(SCREEN_W * SCREEN_H);
  localparam logic [5:0] DELIM_CODE = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PIXEL = 3'd3,
    ST_DONE  = 3'd4
  } fw_state_t;

  // Glyph table contents: code 0 is blank, code 1 is two vertical bars.
  function automatic logic [7:0] glyph_row(input logic [5:0] code, input logic [2:0] row);
    logic [7:0] row_bits;
    if (code == 6'd0) begin
      row_bits = 8'h00;
    end else if (code == 6'd1) begin
      row_bits = 8'h81;
    end else begin
      row_bits = ({2'b00, code} * 8'd29) + ({5'b00000, row} * 8'd53) + 8'd7;
    end
    return row_bits;
  endfunction

  function automatic logic [16:0] pixel_addr(input logic [5:0] cx, input logic [4:0] cy,
                                             input logic [2:0] row, input logic [2:0] col);
    logic [16:0] py;
    logic [16:0] px;
    py = {9'd0, cy, 3'd0} + {14'd0, row};
    px = {8'd0, cx, 3'd0} + {14'd0, col};
    return (py * 17'(SCREEN_W)) + px;
  endfunction

endpackage

// File: rtl/font_rom.sv
// 512x8 glyph table addressed by {code,row}, one-cycle registered output.
module font_rom
  import font_writer_pkg::*;
(
  input  logic       clk,
  input  logic [8:0] addr,
  output logic [7:0] data
);

  // Registered table read.
  always_ff @(posedge clk) begin
    data <= glyph_row(addr[8:3], addr[2:0]);
  end

endmodule

// File: rtl/font_writer.sv
// Draws one 8x8 glyph into a 320x240 1-bit frame buffer at the text cursor.
// Define FW_BG_CLEAR_EN to also write background (0) pixels; timing is unchanged.
module font_writer
  import font_writer_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 FWStart,
  input  logic [5:0]           CharNumber,
  input  logic                 FWColor,
  input  logic                 CursorSet,
  input  logic [5:0]           CursorX,
  input  logic [4:0]           CursorY,
  output logic                 FWEnd,
  output logic                 Busy,
  output logic                 FBWrite,
  output logic [FB_ADDR_W-1:0] FBAddr,
  output logic                 FBData,
  input  logic                 FBAck
);

`ifdef FW_BG_CLEAR_EN
  localparam logic BG_CLEAR = 1'b1;
`else
  localparam logic BG_CLEAR = 1'b0;
`endif

  fw_state_t   state_r;
  logic [5:0]  code_r;
  logic        color_r;
  logic [2:0]  row_r;
  logic [2:0]  col_r;
  logic [7:0]  bits_r;
  logic [5:0]  cur_x_r;
  logic [4:0]  cur_y_r;

  logic [8:0]  rom_addr_s;
  logic [7:0]  rom_data_s;
  logic [2:0]  nxt_col_s;
  logic [7:0]  nxt_bits_s;
  logic        nxt_bit_s;
  logic        nxt_wr_s;
  logic        nxt_data_s;
  logic [16:0] nxt_addr_s;
  logic        pixel_done_s;

  assign rom_addr_s = {code_r, row_r};

  font_rom u_rom (
    .clk  (Clock),
    .addr (rom_addr_s),
    .data (rom_data_s)
  );

  // Next pixel to present: column 0 straight from the ROM in LOAD, else col+1 from the latched row.
  always_comb begin
    nxt_col_s  = 3'd0;
    nxt_bits_s = 8'h00;
    if (state_r == ST_LOAD) begin
      nxt_col_s  = 3'd0;
      nxt_bits_s = rom_data_s;
    end else begin
      nxt_col_s  = col_r + 3'd1;
      nxt_bits_s = bits_r;
    end
    nxt_bit_s    = nxt_bits_s[3'd7 - nxt_col_s];
    nxt_wr_s     = nxt_bit_s | BG_CLEAR;
    nxt_data_s   = nxt_bit_s & color_r;
    nxt_addr_s   = pixel_addr(cur_x_r, cur_y_r, row_r, nxt_col_s);
    pixel_done_s = ~FBWrite | FBAck;
  end

  // Glyph FSM with registered frame-buffer handshake and status outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      code_r  <= 6'd0;
      color_r <= 1'b0;
      row_r   <= 3'd0;
      col_r   <= 3'd0;
      bits_r  <= 8'h00;
      cur_x_r <= 6'd0;
      cur_y_r <= 5'd0;
      FWEnd   <= 1'b0;
      Busy    <= 1'b0;
      FBWrite <= 1'b0;
      FBAddr  <= '0;
      FBData  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          FWEnd <= 1'b0;
          if (CursorSet) begin
            cur_x_r <= CursorX;
            cur_y_r <= CursorY;
          end
          if (FWStart) begin
            code_r  <= CharNumber;
            color_r <= FWColor;
            row_r   <= 3'd0;
            Busy    <= 1'b1;
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (code_r == DELIM_CODE) begin
            FWEnd   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bits_r  <= rom_data_s;
          col_r   <= nxt_col_s;
          FBWrite <= nxt_wr_s;
          FBAddr  <= nxt_addr_s;
          FBData  <= nxt_data_s;
          state_r <= ST_PIXEL;
        end
        ST_PIXEL: begin
          if (pixel_done_s) begin
            if (col_r != 3'(GLYPH_SIZE - 1)) begin
              col_r   <= nxt_col_s;
              FBWrite <= nxt_wr_s;
              FBAddr  <= nxt_addr_s;
              FBData  <= nxt_data_s;
            end else begin
              FBWrite <= 1'b0;
              if (row_r != 3'(GLYPH_SIZE - 1)) begin
                row_r   <= row_r + 3'd1;
                state_r <= ST_FETCH;
              end else begin
                FWEnd   <= 1'b1;
                state_r <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          FWEnd   <= 1'b0;
          Busy    <= 1'b0;
          state_r <= ST_IDLE;
          // The delimiter code never moves the cursor.
          if (code_r != DELIM_CODE) begin
            if (cur_x_r == 6'(TEXT_COLS - 1)) begin
              cur_x_r <= 6'd0;
              cur_y_r <= (cur_y_r == 5'(TEXT_ROWS - 1)) ? 5'd0 : cur_y_r + 5'd1;
            end else begin
              cur_x_r <= cur_x_r + 6'd1;
            end
          end
        end
        default: begin
          FWEnd   <= 1'b0;
          Busy    <= 1'b0;
          FBWrite <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_font_writer.sv
// Self-checking bench for font_writer: a pixel-list reference model, random codes,
// colours, cursors and FBAck stalls; honours FW_BG_CLEAR_EN like the design.
module tb_font_writer;

`ifdef FW_BG_CLEAR_EN
  localparam bit BG = 1'b1;
`else
  localparam bit BG = 1'b0;
`endif
  localparam int BUDGET = 400;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        FWStart;
  logic [5:0]  CharNumber;
  logic        FWColor;
  logic        CursorSet;
  logic [5:0]  CursorX;
  logic [4:0]  CursorY;
  logic        FWEnd;
  logic        Busy;
  logic        FBWrite;
  logic [16:0] FBAddr;
  logic        FBData;
  logic        FBAck;

  int n_cmp  = 0;
  int n_fail = 0;
  int cx     = 0;
  int cy     = 0;

  always #5 Clock = ~Clock;

  font_writer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .FWStart    (FWStart),
    .CharNumber (CharNumber),
    .FWColor    (FWColor),
    .CursorSet  (CursorSet),
    .CursorX    (CursorX),
    .CursorY    (CursorY),
    .FWEnd      (FWEnd),
    .Busy       (Busy),
    .FBWrite    (FBWrite),
    .FBAddr     (FBAddr),
    .FBData     (FBData),
    .FBAck      (FBAck)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int font_row(input int c, input int r);
    if (c == 0) return 0;
    if (c == 1) return 'h81;
    return (c * 29 + r * 53 + 7) % 256;
  endfunction

  task automatic set_cursor(input int x, input int y);
    @(negedge Clock);
    CursorSet = 1'b1; CursorX = 6'(x); CursorY = 5'(y);
    @(negedge Clock);
    CursorSet = 1'b0;
    cx = x; cy = y;
  endtask

  // Draw one glyph and check every presented pixel, the handshake hold, timing and Busy.
  task automatic run_glyph(input int code, input int color, input bit set_cur, input int sx,
                           input int sy, input int first_wait, input int max_wait, input bit poke);
    int exp_addr[$];
    int exp_data[$];
    int waits[$];
    int idx = 0, stall = 0, end_cyc = 0, busy_bad = 0, exp_end;
    bit seen_end = 1'b0;
    if (set_cur) begin cx = sx; cy = sy; end
    if (code != 63) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          int b;
          b = (font_row(code, r) >> (7 - c)) & 1;
          if (b == 1 || BG) begin
            exp_addr.push_back((cy * 8 + r) * 320 + cx * 8 + c);
            exp_data.push_back(b == 1 ? color : 0);
            waits.push_back(waits.size() == 0 ? first_wait : int'($urandom_range(0, max_wait)));
          end
        end
      end
      exp_end = 81;
      foreach (waits[i]) exp_end += waits[i];
    end else begin
      exp_end = 2;
    end
    @(negedge Clock);
    FWStart = 1'b1; CharNumber = 6'(code); FWColor = 1'(color);
    CursorSet = set_cur; CursorX = 6'(sx); CursorY = 5'(sy);
    for (int cyc = 1; cyc <= BUDGET && !seen_end; cyc++) begin
      @(negedge Clock);
      if (cyc == 1) begin FWStart = 1'b0; CursorSet = 1'b0; end
      if (poke && cyc == 20) begin
        FWStart = 1'b1; CursorSet = 1'b1;
        CharNumber = 6'($urandom_range(0, 63)); CursorX = 6'($urandom_range(0, 39));
        CursorY = 5'($urandom_range(0, 29)); FWColor = 1'($urandom_range(0, 1));
      end
      if (poke && cyc == 21) begin FWStart = 1'b0; CursorSet = 1'b0; end
      if (Busy !== 1'b1) busy_bad++;
      if (FBWrite === 1'b1) begin
        if (idx < exp_addr.size()) begin
          check("pix_addr", 32'(FBAddr), 32'(exp_addr[idx]));
          check("pix_data", 32'(FBData), 32'(exp_data[idx]));
          if (stall < waits[idx]) begin FBAck = 1'b0; stall++; end
          else begin FBAck = 1'b1; idx++; stall = 0; end
        end else begin
          check("extra_write", 32'(idx + 1), 32'(exp_addr.size()));
          FBAck = 1'b1; idx++;
        end
      end else begin
        FBAck = 1'($urandom_range(0, 1));
      end
      if (FWEnd === 1'b1) begin seen_end = 1'b1; end_cyc = cyc; end
    end
    check("fwend_seen", 32'(seen_end), 32'd1);
    check("fwend_cycle", 32'(end_cyc), 32'(exp_end));
    check("write_count", 32'(idx), 32'(exp_addr.size()));
    check("busy_during", 32'(busy_bad), 32'd0);
    @(negedge Clock);
    check("busy_after", 32'(Busy), 32'd0);
    check("fwend_pulse", 32'(FWEnd), 32'd0);
    if (code != 63) begin
      cx = cx + 1;
      if (cx == 40) begin cx = 0; cy = (cy + 1) % 30; end
    end
  endtask

  // Reset at cycle 40 of a glyph; nothing may be written or ended afterwards.
  task automatic run_abort(input int code);
    int wr = 0, ends = 0;
    @(negedge Clock);
    FWStart = 1'b1; CharNumber = 6'(code); FWColor = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge Clock);
      FWStart = 1'b0; FBAck = 1'b1;
    end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_fbwrite", 32'(FBWrite), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_fwend", 32'(FWEnd), 32'd0);
    for (int i = 0; i < 90; i++) begin
      @(negedge Clock);
      if (FBWrite !== 1'b0) wr++;
      if (FWEnd !== 1'b0) ends++;
    end
    check("abort_no_write", 32'(wr), 32'd0);
    check("abort_no_end", 32'(ends), 32'd0);
    cx = 0; cy = 0;
  endtask

  initial begin
    Reset = 1'b1; FWStart = 1'b0; CharNumber = 6'd0; FWColor = 1'b0;
    CursorSet = 1'b0; CursorX = 6'd0; CursorY = 5'd0; FBAck = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_fwend", 32'(FWEnd), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_fbwrite", 32'(FBWrite), 32'd0);
    check("rst_fbaddr", 32'(FBAddr), 32'd0);
    check("rst_fbdata", 32'(FBData), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    run_glyph(1, 1, 1'b0, 0, 0, 0, 0, 1'b0);
    run_glyph(1, 1, 1'b0, 0, 0, 5, 0, 1'b0);
    run_glyph(63, 1, 1'b0, 0, 0, 0, 0, 1'b0);
    run_glyph(0, 1, 1'b0, 0, 0, 0, 0, 1'b0);
    run_glyph(int'($urandom_range(2, 62)), 1, 1'b1, 39, 29, 0, 0, 1'b0);
    run_glyph(int'($urandom_range(2, 62)), int'($urandom_range(0, 1)), 1'b0, 0, 0, 0, 2, 1'b1);
    set_cursor(39, 5);
    run_glyph(int'($urandom_range(1, 62)), 1, 1'b0, 0, 0, 1, 2, 1'b0);
    run_glyph(int'($urandom_range(1, 62)), 0, 1'b0, 0, 0, 0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_glyph(int'($urandom_range(0, 62)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 39)), int'($urandom_range(0, 29)), 0, 2, 1'($urandom_range(0, 1)));
    end
    run_abort(1);
    run_glyph(int'($urandom_range(1, 62)), 1, 1'b0, 0, 0, 0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
